// File: rtl/tally_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tally_pkg
// Description : Shared FSM state encoding and win threshold for the
//               bitcount_tally block and its bitcount stage.
// Revision    : 1.0 - initial release
// ============================================================================
package tally_pkg;

  // A word "wins" when its ones count is strictly greater than this value
  localparam int ONES_WIN_THRESHOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tally_state_t;

endpackage : tally_pkg
`default_nettype wire

// File: rtl/bitcount_tally_if.sv
`default_nettype none
// ============================================================================
// Interface   : bitcount_tally_if
// Description : Valid/ready word stream feeding the bitcount_tally block.
// Revision    : 1.0 - initial release
// ============================================================================
interface bitcount_tally_if #(
  parameter int D_WIDTH = 16
);
  logic [D_WIDTH-1:0] d_i;
  logic               d_valid_i;
  logic               d_ready_o;

  // Word producer
  modport master (
    output d_i,
    output d_valid_i,
    input  d_ready_o
  );

  // Word consumer (the tally block)
  modport slave (
    input  d_i,
    input  d_valid_i,
    output d_ready_o
  );
endinterface : bitcount_tally_if
`default_nettype wire

// File: rtl/bitcount.sv
`default_nettype none
// ============================================================================
// Module      : bitcount
// Description : Combinational 16-bit population count; win_o is high when the
//               word holds more than ONES_WIN_THRESHOLD ones.
// Revision    : 1.0 - initial release
// ============================================================================
module bitcount
  import tally_pkg::*;
#(
  parameter int D_WIDTH = 16
) (
  input  wire logic [D_WIDTH-1:0] d_i,
  output logic                    win_o
);

  logic [15:0] w_pair;
  logic [15:0] w_nib;
  logic [3:0]  w_byte0;
  logic [3:0]  w_byte1;
  logic [4:0]  w_ones;

  // SWAR popcount: 2-bit sums, then 4-bit sums, then per-byte and total sums.
  // Nibble sums are at most 4, so each byte sum fits in 4 bits.
  always_comb begin
    w_pair  = d_i - ((d_i >> 1) & 16'h5555);
    w_nib   = (w_pair & 16'h3333) + ((w_pair >> 2) & 16'h3333);
    w_byte0 = w_nib[3:0]  + w_nib[7:4];
    w_byte1 = w_nib[11:8] + w_nib[15:12];
    w_ones  = {1'b0, w_byte0} + {1'b0, w_byte1};
    win_o   = (w_ones > 5'(ONES_WIN_THRESHOLD));
  end

endmodule : bitcount
`default_nettype wire

// File: rtl/bitcount_tally.sv
`default_nettype none
// ============================================================================
// Module      : bitcount_tally
// Description : Accepts a burst of len_i words, registers each accepted word,
//               classifies it through bitcount one cycle later and counts the
//               winners. Reports win count and majority flag with a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bitcount_tally
  import tally_pkg::*;
#(
  parameter int D_WIDTH   = 16,
  parameter int CNT_WIDTH = 8
) (
  input  wire logic                 clk_i,
  input  wire logic                 reset_n_i,
  input  wire logic                 start_i,
  input  wire logic [CNT_WIDTH-1:0] len_i,
  bitcount_tally_if.slave           s_if,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [CNT_WIDTH-1:0]      win_cnt_o,
  output logic                      majority_o
);

  tally_state_t         r_state;
  logic [CNT_WIDTH-1:0] r_len;
  logic [CNT_WIDTH-1:0] r_rem;
  logic [CNT_WIDTH-1:0] r_win_cnt;
  logic [D_WIDTH-1:0]   r_stage;
  logic                 r_stage_vld;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_win;
  logic                 w_majority;

  // Stage-2 classifier sees the registered word, one cycle after handshake
  bitcount #(
    .D_WIDTH (D_WIDTH)
  ) u_bitcount (
    .d_i   (r_stage),
    .win_o (w_win)
  );

  // Majority compare carried out one bit wider so 2*win never wraps
  always_comb begin
    w_majority = ({r_win_cnt, 1'b0} > {1'b0, r_len});
  end

  // Control FSM, stage register and win counter; outputs registered with state
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_rem       <= '0;
      r_win_cnt   <= '0;
      r_stage     <= '0;
      r_stage_vld <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_stage_vld <= 1'b0;

      // Stage 2: count the word registered in the previous cycle
      if (r_stage_vld && w_win) begin
        r_win_cnt <= r_win_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_len     <= len_i;
            r_rem     <= len_i;
            r_win_cnt <= '0;
            r_busy    <= 1'b1;
            if (len_i == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
              r_ready <= 1'b1;
            end
          end
        end

        ST_ACCUM: begin
          if (s_if.d_valid_i) begin
            r_stage     <= s_if.d_i;
            r_stage_vld <= 1'b1;
            r_rem       <= r_rem - 1'b1;
            if (r_rem == CNT_WIDTH'(1)) begin
              r_state <= ST_DRAIN;
              r_ready <= 1'b0;
            end
          end
        end

        // Last word is being counted this cycle; results final next cycle
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_if.d_ready_o = r_ready;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign win_cnt_o      = r_win_cnt;
  assign majority_o     = w_majority;

endmodule : bitcount_tally
`default_nettype wire

// File: tb/tb_bitcount_tally.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitcount_tally
// Description : Self-checking bench for bitcount_tally: table of bursts with
//               hand-computed results plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitcount_tally;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       start_i;
  logic [7:0] len_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] win_cnt_o;
  logic       majority_o;

  bitcount_tally_if #(.D_WIDTH(16)) u_if ();

  bitcount_tally #(
    .D_WIDTH   (16),
    .CNT_WIDTH (8)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .start_i    (start_i),
    .len_i      (len_i),
    .s_if       (u_if.slave),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .win_cnt_o  (win_cnt_o),
    .majority_o (majority_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // Count every done pulse seen at a rising edge
  always @(posedge clk_i) begin
    if (done_o === 1'b1) done_seen++;
  end

  typedef struct {
    logic [7:0]       len;
    logic [3:0][15:0] w;
    bit               gap;
    logic [7:0]       exp_win;
    logic             exp_maj;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one burst from IDLE and checks handshake, done timing and results
  task automatic run_burst(input logic [7:0] len, input logic [3:0][15:0] w,
                           input bit gap, input logic [7:0] ew, input logic em,
                           input string tag);
    int d0;
    d0 = done_seen;
    start_i = 1'b1;
    len_i   = len;
    step();
    start_i = 1'b0;
    len_i   = 8'hAA;
    if (len == 8'd0) begin
      chk({tag, " len0 done"}, done_o, 1);
      chk({tag, " len0 ready"}, u_if.d_ready_o, 0);
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        if (gap && i > 0) begin
          u_if.d_valid_i = 1'b0;
          u_if.d_i       = 16'hFFFF;
          chk({tag, " gap ready"}, u_if.d_ready_o, 1);
          step();
        end
        u_if.d_valid_i = 1'b1;
        u_if.d_i       = w[i];
        chk({tag, " accum ready"}, u_if.d_ready_o, 1);
        step();
      end
      u_if.d_valid_i = 1'b1;
      u_if.d_i       = 16'hFFFF;
      chk({tag, " drain ready"}, u_if.d_ready_o, 0);
      chk({tag, " drain done"}, done_o, 0);
      chk({tag, " drain busy"}, busy_o, 1);
      step();
      chk({tag, " done pulse"}, done_o, 1);
    end
    chk({tag, " win"}, win_cnt_o, ew);
    chk({tag, " maj"}, majority_o, em);
    chk({tag, " done busy"}, busy_o, 1);
    u_if.d_valid_i = 1'b0;
    step();
    chk({tag, " idle done"}, done_o, 0);
    chk({tag, " idle busy"}, busy_o, 0);
    chk({tag, " hold win"}, win_cnt_o, ew);
    chk({tag, " hold maj"}, majority_o, em);
    chk({tag, " one done"}, done_seen - d0, 1);
  endtask

  initial begin
    int d0;
    logic [3:0][15:0] wv;

    vecs[0] = '{len: 8'd4, w: {16'h0000, 16'h01FF, 16'h00FF, 16'hFFFF}, gap: 1'b0, exp_win: 8'd2, exp_maj: 1'b0};
    vecs[1] = '{len: 8'd3, w: {16'h0000, 16'h0001, 16'hF0FF, 16'hFFFF}, gap: 1'b1, exp_win: 8'd2, exp_maj: 1'b1};
    vecs[2] = '{len: 8'd0, w: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, gap: 1'b0, exp_win: 8'd0, exp_maj: 1'b0};
    vecs[3] = '{len: 8'd1, w: {16'h0000, 16'h0000, 16'h0000, 16'h00FF}, gap: 1'b0, exp_win: 8'd0, exp_maj: 1'b0};
    vecs[4] = '{len: 8'd2, w: {16'h0000, 16'h0000, 16'h0000, 16'h01FF}, gap: 1'b1, exp_win: 8'd1, exp_maj: 1'b0};
    vecs[5] = '{len: 8'd3, w: {16'h0000, 16'hAAAA, 16'h7FFF, 16'hFF80}, gap: 1'b0, exp_win: 8'd2, exp_maj: 1'b1};

    reset_n_i      = 1'b0;
    start_i        = 1'b0;
    len_i          = 8'd0;
    u_if.d_i       = 16'h0000;
    u_if.d_valid_i = 1'b0;
    #7;
    chk("reset ready", u_if.d_ready_o, 0);
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset win", win_cnt_o, 0);
    chk("reset maj", majority_o, 0);
    #10;
    reset_n_i = 1'b1;
    step();

    // Idle with random valid traffic: nothing must move
    d0 = done_seen;
    for (int i = 0; i < 16; i++) begin
      u_if.d_valid_i = 1'($urandom_range(0, 1));
      u_if.d_i       = 16'($urandom);
      step();
      chk("idle ready", u_if.d_ready_o, 0);
      chk("idle busy", busy_o, 0);
      chk("idle win", win_cnt_o, 0);
      chk("idle maj", majority_o, 0);
    end
    chk("idle no done", done_seen - d0, 0);
    u_if.d_valid_i = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_burst(vecs[v].len, vecs[v].w, vecs[v].gap, vecs[v].exp_win, vecs[v].exp_maj,
                $sformatf("vec%0d", v));
    end

    // Full-length burst of winning words: count reaches 255 without wrapping
    d0 = done_seen;
    start_i = 1'b1;
    len_i   = 8'd255;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 255; i++) begin
      u_if.d_valid_i = 1'b1;
      u_if.d_i       = 16'hFFFF;
      if (i == 0 || i == 254) chk("len255 ready", u_if.d_ready_o, 1);
      step();
    end
    u_if.d_valid_i = 1'b0;
    chk("len255 drain done", done_o, 0);
    step();
    chk("len255 done", done_o, 1);
    chk("len255 win", win_cnt_o, 255);
    chk("len255 maj", majority_o, 1);
    step();
    chk("len255 one done", done_seen - d0, 1);

    // Reset in the middle of a 5-word burst
    d0 = done_seen;
    start_i = 1'b1;
    len_i   = 8'd5;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      u_if.d_valid_i = 1'b1;
      u_if.d_i       = 16'hFFFF;
      step();
    end
    u_if.d_valid_i = 1'b0;
    step();
    chk("mid win before reset", win_cnt_o, 2);
    chk("mid busy before reset", busy_o, 1);
    reset_n_i = 1'b0;
    #1;
    chk("mid reset win", win_cnt_o, 0);
    chk("mid reset maj", majority_o, 0);
    chk("mid reset busy", busy_o, 0);
    chk("mid reset ready", u_if.d_ready_o, 0);
    #10;
    reset_n_i = 1'b1;
    step();
    chk("mid reset no done", done_seen - d0, 0);
    chk("mid reset idle busy", busy_o, 0);
    wv = {16'h0000, 16'h0000, 16'h0000, 16'h0FFF};
    run_burst(8'd1, wv, 1'b0, 8'd1, 1'b1, "post reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bitcount_tally
`default_nettype wire
